rs_issue_scheduler: RTL and testbench

//  Reservation-station scheduler for the integer ALU/branch unit of the OoO core.

---
 rtl/rs_issue_scheduler_pkg.sv | 45 ++++
 rtl/rs_age_matrix.sv | 53 +++++
 rtl/rs_issue_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_rs_issue_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_issue_scheduler_pkg.sv
// Shared types for the integer reservation station: RV32I field encodings and
// the per-entry operation payload.
package rs_issue_scheduler_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned TAG_W_DEF = 6;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011
  } opcode_e;

  typedef enum logic [2:0] {
    F3_ADD_SUB = 3'b000,
    F3_SLL     = 3'b001,
    F3_SLT     = 3'b010,
    F3_SLTU    = 3'b011,
    F3_XOR     = 3'b100,
    F3_SRL_SRA = 3'b101,
    F3_OR      = 3'b110,
    F3_AND     = 3'b111
  } func3_e;

  typedef enum logic [6:0] {
    F7_BASE = 7'b0000000,
    F7_ALT  = 7'b0100000
  } func7_e;

  // Decoded op fields held in an entry; tags and operands are sized by the
  // instantiating station and live alongside this payload.
  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    word_t      imm;
  } rs_op_t;

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix for the reservation station: tracks relative order of entries and
// picks the oldest member of a request mask.
module rs_age_matrix #(
  parameter int unsigned NUM_ENTRIES = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           alloc_en,
  input  logic [$clog2(NUM_ENTRIES)-1:0] alloc_idx,
  input  logic [NUM_ENTRIES-1:0]         valid_mask,
  input  logic [NUM_ENTRIES-1:0]         req_mask,
  output logic [NUM_ENTRIES-1:0]         oldest_c
);

  // age_q[i][j] set means entry i is older than entry j
  logic [NUM_ENTRIES-1:0] age_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] age_d [NUM_ENTRIES];

  // New entry is younger than every currently valid entry; freed rows go stale harmlessly
  always_comb begin
    age_d = age_q;
    if (alloc_en) begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
        age_d[alloc_idx][i] = 1'b0;
        age_d[i][alloc_idx] = valid_mask[i];
      end
    end
  end

  // An entry is oldest when no other requester is older than it
  always_comb begin
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      oldest_c[i] = req_mask[i];
      for (int j = 0; j < int'(NUM_ENTRIES); j++) begin
        if ((j != i) && req_mask[j] && age_q[j][i]) begin
          oldest_c[i] = 1'b0;
        end
      end
    end
  end

  // Matrix state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
        age_q[i] <= '0;
      end
    end else begin
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/rs_issue_scheduler.sv
// Reservation-station issue scheduler for the integer ALU/branch unit.
// Captures operands from dispatch and the CDB, issues the oldest ready entry.
// Optional RS_WAKEUP_BYPASS_EN: CDB match in the current cycle counts as ready
// and forwards cdb_value onto the issue operands (back-to-back dependent issue).
module rs_issue_scheduler
  import rs_issue_scheduler_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned TAG_W       = TAG_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [6:0]                   disp_opcode,
  input  logic [2:0]                   disp_func3,
  input  logic [6:0]                   disp_func7,
  input  logic [XLEN-1:0]              disp_imm,
  input  logic [TAG_W-1:0]             disp_rd_tag,
  input  logic                         disp_rs1_rdy,
  input  logic [TAG_W-1:0]             disp_rs1_tag,
  input  logic [XLEN-1:0]              disp_rs1_val,
  input  logic                         disp_rs2_rdy,
  input  logic [TAG_W-1:0]             disp_rs2_tag,
  input  logic [XLEN-1:0]              disp_rs2_val,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [XLEN-1:0]              cdb_value,
  output logic                         iss_valid,
  input  logic                         iss_ready,
  output logic [6:0]                   iss_opcode,
  output logic [2:0]                   iss_func3,
  output logic [6:0]                   iss_func7,
  output logic [XLEN-1:0]              iss_imm,
  output logic [TAG_W-1:0]             iss_rd_tag,
  output logic [XLEN-1:0]              iss_rs1_val,
  output logic [XLEN-1:0]              iss_rs2_val,
  output logic [$clog2(NUM_ENTRIES):0] occupancy
);

  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [NUM_ENTRIES-1:0] rs1_rdy_q, rs1_rdy_d, rs2_rdy_q, rs2_rdy_d;
  rs_op_t                 op_q [NUM_ENTRIES];
  rs_op_t                 op_d [NUM_ENTRIES];
  logic [TAG_W-1:0]       rd_tag_q [NUM_ENTRIES];
  logic [TAG_W-1:0]       rd_tag_d [NUM_ENTRIES];
  logic [TAG_W-1:0]       rs1_tag_q [NUM_ENTRIES];
  logic [TAG_W-1:0]       rs1_tag_d [NUM_ENTRIES];
  logic [TAG_W-1:0]       rs2_tag_q [NUM_ENTRIES];
  logic [TAG_W-1:0]       rs2_tag_d [NUM_ENTRIES];
  word_t                  rs1_val_q [NUM_ENTRIES];
  word_t                  rs1_val_d [NUM_ENTRIES];
  word_t                  rs2_val_q [NUM_ENTRIES];
  word_t                  rs2_val_d [NUM_ENTRIES];
  logic                   disp_ready_q, disp_ready_d;
  logic [CNT_W-1:0]       occupancy_q, occupancy_d;

  logic [NUM_ENTRIES-1:0] wake1_c, wake2_c, ready_c, sel_oh_c;
  logic [IDX_W-1:0]       alloc_idx_c, sel_idx_c;
  logic                   alloc_en_c, any_ready_c, issue_fire_c;

  // CDB tag match against each waiting source operand
  always_comb begin
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      wake1_c[i] = valid_q[i] && !rs1_rdy_q[i] && cdb_valid && (rs1_tag_q[i] == cdb_tag);
      wake2_c[i] = valid_q[i] && !rs2_rdy_q[i] && cdb_valid && (rs2_tag_q[i] == cdb_tag);
    end
  end

`ifdef RS_WAKEUP_BYPASS_EN
  assign ready_c = valid_q & (rs1_rdy_q | wake1_c) & (rs2_rdy_q | wake2_c);
`else
  assign ready_c = valid_q & rs1_rdy_q & rs2_rdy_q;
`endif

  assign any_ready_c  = |ready_c;
  assign issue_fire_c = any_ready_c && iss_ready;
  assign alloc_en_c   = disp_valid && disp_ready_q && !flush;

  rs_age_matrix #(
    .NUM_ENTRIES(NUM_ENTRIES)
  ) u_age (
    .clk       (clk),
    .rst_n     (rst_n),
    .alloc_en  (alloc_en_c),
    .alloc_idx (alloc_idx_c),
    .valid_mask(valid_q),
    .req_mask  (ready_c),
    .oldest_c  (sel_oh_c)
  );

  // Lowest-index free slot for allocation, and index of the selected entry
  always_comb begin
    alloc_idx_c = '0;
    sel_idx_c   = '0;
    for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx_c = IDX_W'(i);
    end
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      if (sel_oh_c[i]) sel_idx_c = IDX_W'(i);
    end
  end

  // Issue payload of the selected entry, zero when nothing is ready
  always_comb begin
    iss_opcode  = '0;
    iss_func3   = '0;
    iss_func7   = '0;
    iss_imm     = '0;
    iss_rd_tag  = '0;
    iss_rs1_val = '0;
    iss_rs2_val = '0;
    if (any_ready_c) begin
      iss_opcode  = op_q[sel_idx_c].opcode;
      iss_func3   = op_q[sel_idx_c].func3;
      iss_func7   = op_q[sel_idx_c].func7;
      iss_imm     = op_q[sel_idx_c].imm;
      iss_rd_tag  = rd_tag_q[sel_idx_c];
      iss_rs1_val = rs1_val_q[sel_idx_c];
      iss_rs2_val = rs2_val_q[sel_idx_c];
`ifdef RS_WAKEUP_BYPASS_EN
      if (wake1_c[sel_idx_c]) iss_rs1_val = cdb_value;
      if (wake2_c[sel_idx_c]) iss_rs2_val = cdb_value;
`endif
    end
  end

  assign iss_valid  = any_ready_c;
  assign disp_ready = disp_ready_q;
  assign occupancy  = occupancy_q;

  // Next entry state: wakeup, issue free, allocation, then flush overrides valid
  always_comb begin
    valid_d   = valid_q;
    rs1_rdy_d = rs1_rdy_q;
    rs2_rdy_d = rs2_rdy_q;
    op_d      = op_q;
    rd_tag_d  = rd_tag_q;
    rs1_tag_d = rs1_tag_q;
    rs2_tag_d = rs2_tag_q;
    rs1_val_d = rs1_val_q;
    rs2_val_d = rs2_val_q;

    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      if (wake1_c[i]) begin
        rs1_rdy_d[i] = 1'b1;
        rs1_val_d[i] = cdb_value;
      end
      if (wake2_c[i]) begin
        rs2_rdy_d[i] = 1'b1;
        rs2_val_d[i] = cdb_value;
      end
    end

    if (issue_fire_c) valid_d[sel_idx_c] = 1'b0;

    if (alloc_en_c) begin
      valid_d[alloc_idx_c]   = 1'b1;
      op_d[alloc_idx_c]      = '{opcode: disp_opcode, func3: disp_func3,
                                 func7: disp_func7, imm: disp_imm};
      rd_tag_d[alloc_idx_c]  = disp_rd_tag;
      rs1_tag_d[alloc_idx_c] = disp_rs1_tag;
      rs2_tag_d[alloc_idx_c] = disp_rs2_tag;
      // Capture a same-cycle broadcast so the producer's result is not missed
      rs1_rdy_d[alloc_idx_c] = disp_rs1_rdy || (cdb_valid && (cdb_tag == disp_rs1_tag));
      rs2_rdy_d[alloc_idx_c] = disp_rs2_rdy || (cdb_valid && (cdb_tag == disp_rs2_tag));
      rs1_val_d[alloc_idx_c] = disp_rs1_rdy ? disp_rs1_val : cdb_value;
      rs2_val_d[alloc_idx_c] = disp_rs2_rdy ? disp_rs2_val : cdb_value;
    end

    if (flush) valid_d = '0;

    occupancy_d = '0;
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      occupancy_d = occupancy_d + CNT_W'(valid_d[i]);
    end
    disp_ready_d = ~&valid_d;
  end

  // Entry and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= '0;
      rs1_rdy_q    <= '0;
      rs2_rdy_q    <= '0;
      disp_ready_q <= 1'b1;
      occupancy_q  <= '0;
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
        op_q[i]      <= '0;
        rd_tag_q[i]  <= '0;
        rs1_tag_q[i] <= '0;
        rs2_tag_q[i] <= '0;
        rs1_val_q[i] <= '0;
        rs2_val_q[i] <= '0;
      end
    end else begin
      valid_q      <= valid_d;
      rs1_rdy_q    <= rs1_rdy_d;
      rs2_rdy_q    <= rs2_rdy_d;
      disp_ready_q <= disp_ready_d;
      occupancy_q  <= occupancy_d;
      op_q         <= op_d;
      rd_tag_q     <= rd_tag_d;
      rs1_tag_q    <= rs1_tag_d;
      rs2_tag_q    <= rs2_tag_d;
      rs1_val_q    <= rs1_val_d;
      rs2_val_q    <= rs2_val_d;
    end
  end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Bench for rs_issue_scheduler: directed scenarios plus random traffic, checked
// by a scoreboard fed from a queue-ordered reference model.
module tb_rs_issue_scheduler;
  import rs_issue_scheduler_pkg::*;

  localparam int unsigned N  = 8;
  localparam int unsigned TW = 6;
  localparam int unsigned CW = $clog2(N) + 1;
`ifdef RS_WAKEUP_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush, disp_valid, disp_ready;
  logic [6:0] disp_opcode, disp_func7, iss_opcode, iss_func7;
  logic [2:0] disp_func3, iss_func3;
  logic [31:0] disp_imm, disp_rs1_val, disp_rs2_val, cdb_value;
  logic [31:0] iss_imm, iss_rs1_val, iss_rs2_val;
  logic [TW-1:0] disp_rd_tag, disp_rs1_tag, disp_rs2_tag, cdb_tag, iss_rd_tag;
  logic disp_rs1_rdy, disp_rs2_rdy, cdb_valid, iss_valid, iss_ready;
  logic [CW-1:0] occupancy;

  always #5 clk = ~clk;

  rs_issue_scheduler #(.NUM_ENTRIES(N), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_opcode(disp_opcode), .disp_func3(disp_func3), .disp_func7(disp_func7),
    .disp_imm(disp_imm), .disp_rd_tag(disp_rd_tag),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_tag(disp_rs1_tag), .disp_rs1_val(disp_rs1_val),
    .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_tag(disp_rs2_tag), .disp_rs2_val(disp_rs2_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_opcode(iss_opcode), .iss_func3(iss_func3), .iss_func7(iss_func7),
    .iss_imm(iss_imm), .iss_rd_tag(iss_rd_tag),
    .iss_rs1_val(iss_rs1_val), .iss_rs2_val(iss_rs2_val),
    .occupancy(occupancy)
  );

  typedef struct {
    logic [6:0] opc; logic [2:0] f3; logic [6:0] f7; logic [31:0] imm; logic [TW-1:0] rd;
    bit r1; logic [TW-1:0] t1; logic [31:0] v1;
    bit r2; logic [TW-1:0] t2; logic [31:0] v2;
  } ment_t;

  typedef struct {
    bit iv; logic [6:0] opc; logic [2:0] f3; logic [6:0] f7; logic [31:0] imm;
    logic [TW-1:0] rd; logic [31:0] v1; logic [31:0] v2; bit dr; int occ;
  } exp_t;

  ment_t mq[$];   // model station contents, oldest first
  exp_t  eq[$];   // expected per-cycle DUT response
  exp_t  mon_e;
  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit src_ok(bit r, logic [TW-1:0] t);
    return r || (BYPASS && cdb_valid && (cdb_tag == t));
  endfunction

  // Reference: oldest ready op issues; wakeups, dispatch and flush apply at the edge
  task automatic model_step();
    exp_t e;
    ment_t n;
    int sel;
    e = '{default: '0};
    sel = -1;
    e.dr  = (mq.size() < int'(N));
    e.occ = mq.size();
    for (int i = 0; i < mq.size(); i++) begin
      if (sel < 0 && src_ok(mq[i].r1, mq[i].t1) && src_ok(mq[i].r2, mq[i].t2)) sel = i;
    end
    if (sel >= 0) begin
      e.iv = 1'b1; e.opc = mq[sel].opc; e.f3 = mq[sel].f3; e.f7 = mq[sel].f7;
      e.imm = mq[sel].imm; e.rd = mq[sel].rd;
      e.v1 = mq[sel].r1 ? mq[sel].v1 : cdb_value;
      e.v2 = mq[sel].r2 ? mq[sel].v2 : cdb_value;
    end
    eq.push_back(e);
    if (sel >= 0 && iss_ready) mq.delete(sel);
    for (int i = 0; i < mq.size(); i++) begin
      if (cdb_valid && !mq[i].r1 && mq[i].t1 == cdb_tag) begin mq[i].r1 = 1'b1; mq[i].v1 = cdb_value; end
      if (cdb_valid && !mq[i].r2 && mq[i].t2 == cdb_tag) begin mq[i].r2 = 1'b1; mq[i].v2 = cdb_value; end
    end
    if (disp_valid && e.dr && !flush) begin
      n.opc = disp_opcode; n.f3 = disp_func3; n.f7 = disp_func7; n.imm = disp_imm; n.rd = disp_rd_tag;
      n.t1 = disp_rs1_tag; n.t2 = disp_rs2_tag;
      n.r1 = disp_rs1_rdy || (cdb_valid && cdb_tag == disp_rs1_tag);
      n.r2 = disp_rs2_rdy || (cdb_valid && cdb_tag == disp_rs2_tag);
      n.v1 = disp_rs1_rdy ? disp_rs1_val : cdb_value;
      n.v2 = disp_rs2_rdy ? disp_rs2_val : cdb_value;
      mq.push_back(n);
    end
    if (flush) mq.delete();
  endtask

  // Scoreboard monitor: one expected record per active cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (eq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL scoreboard: no expected record at t=%0t", $time);
      end else begin
        mon_e = eq.pop_front();
        check("iss_valid", 32'(iss_valid), 32'(mon_e.iv));
        check("disp_ready", 32'(disp_ready), 32'(mon_e.dr));
        check("occupancy", 32'(occupancy), 32'(mon_e.occ));
        if (mon_e.iv) begin
          check("iss_opcode", 32'(iss_opcode), 32'(mon_e.opc));
          check("iss_func3", 32'(iss_func3), 32'(mon_e.f3));
          check("iss_func7", 32'(iss_func7), 32'(mon_e.f7));
          check("iss_imm", iss_imm, mon_e.imm);
          check("iss_rd_tag", 32'(iss_rd_tag), 32'(mon_e.rd));
          check("iss_rs1_val", iss_rs1_val, mon_e.v1);
          check("iss_rs2_val", iss_rs2_val, mon_e.v2);
        end
      end
    end
  end

  task automatic clear_in();
    flush = 1'b0; disp_valid = 1'b0; disp_opcode = '0; disp_func3 = '0; disp_func7 = '0;
    disp_imm = '0; disp_rd_tag = '0; disp_rs1_rdy = 1'b0; disp_rs1_tag = '0; disp_rs1_val = '0;
    disp_rs2_rdy = 1'b0; disp_rs2_tag = '0; disp_rs2_val = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; iss_ready = 1'b0;
  endtask

  task automatic disp(input logic [TW-1:0] rd, input bit r1, input logic [TW-1:0] t1,
                      input logic [31:0] v1, input bit r2, input logic [TW-1:0] t2,
                      input logic [31:0] v2);
    disp_valid = 1'b1; disp_opcode = OP_REG; disp_func3 = 3'($urandom_range(0, 7));
    disp_func7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00; disp_imm = $urandom;
    disp_rd_tag = rd; disp_rs1_rdy = r1; disp_rs1_tag = t1; disp_rs1_val = v1;
    disp_rs2_rdy = r2; disp_rs2_tag = t2; disp_rs2_val = v2;
  endtask

  task automatic settle(); #1; model_step(); endtask
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic cyc(); settle(); tick(); endtask

  initial begin
    clear_in();
    #1 rst_n = 1'b0;
    #1;
    check("reset_disp_ready", 32'(disp_ready), 32'd1);
    check("reset_iss_valid", 32'(iss_valid), 32'd0);
    check("reset_occupancy", 32'(occupancy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Ready-at-dispatch ADD issues the next cycle
    clear_in(); disp(6'd1, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd7); cyc();
    clear_in(); iss_ready = 1'b1; settle();
    check("add_iss_valid", 32'(iss_valid), 32'd1);
    check("add_rs1", iss_rs1_val, 32'd5);
    check("add_rs2", iss_rs2_val, 32'd7);
    tick();

    // Wakeup from CDB tag 3
    clear_in(); disp(6'd2, 1'b0, 6'd3, 32'd0, 1'b1, 6'd0, 32'd1); cyc();
    clear_in(); cdb_valid = 1'b1; cdb_tag = 6'd3; cdb_value = 32'hDEAD; iss_ready = 1'b1; settle();
`ifdef RS_WAKEUP_BYPASS_EN
    check("wake_bypass_valid", 32'(iss_valid), 32'd1);
    check("wake_bypass_rs1", iss_rs1_val, 32'hDEAD);
    tick();
    clear_in(); iss_ready = 1'b1; settle();
    check("wake_after_issue_empty", 32'(iss_valid), 32'd0);
    tick();
`else
    check("wake_same_cycle_not_ready", 32'(iss_valid), 32'd0);
    tick();
    clear_in(); iss_ready = 1'b1; settle();
    check("wake_valid", 32'(iss_valid), 32'd1);
    check("wake_rs1", iss_rs1_val, 32'hDEAD);
    tick();
`endif

    // Two ops waiting on tag 9 issue in dispatch order
    clear_in(); disp(6'd4, 1'b0, 6'd9, 32'd0, 1'b1, 6'd0, 32'd2); cyc();
    clear_in(); disp(6'd5, 1'b0, 6'd9, 32'd0, 1'b1, 6'd0, 32'd3); cyc();
    clear_in(); cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_value = 32'h99; cyc();
    clear_in(); iss_ready = 1'b1; settle(); check("age_first", 32'(iss_rd_tag), 32'd4); tick();
    clear_in(); iss_ready = 1'b1; settle(); check("age_second", 32'(iss_rd_tag), 32'd5); tick();

    // Fill the station, then release one entry
    for (int k = 0; k < int'(N); k++) begin
      clear_in(); disp(TW'(k + 8), 1'b0, 6'd20, 32'd0, 1'b1, 6'd0, 32'(k)); cyc();
    end
    clear_in(); settle();
    check("full_disp_ready", 32'(disp_ready), 32'd0);
    check("full_occupancy", 32'(occupancy), 32'd8);
    tick();
    clear_in(); cdb_valid = 1'b1; cdb_tag = 6'd20; cdb_value = 32'h2020; cyc();
    clear_in(); iss_ready = 1'b1; disp(6'd40, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1); settle();
    check("full_oldest_issue", 32'(iss_rd_tag), 32'd8);
    tick();
    clear_in(); settle();
    check("release_disp_ready", 32'(disp_ready), 32'd1);
    check("release_occupancy", 32'(occupancy), 32'd7);
    tick();
    clear_in(); flush = 1'b1; cyc();

    // Operand captured from CDB in the dispatch cycle
    clear_in(); disp(6'd30, 1'b1, 6'd0, 32'd1, 1'b0, 6'd12, 32'd0);
    cdb_valid = 1'b1; cdb_tag = 6'd12; cdb_value = 32'h1234; cyc();
    clear_in(); iss_ready = 1'b1; settle();
    check("alloc_capture_valid", 32'(iss_valid), 32'd1);
    check("alloc_capture_rs2", iss_rs2_val, 32'h1234);
    tick();

    // Flush with five valid entries and a concurrent dispatch
    for (int k = 0; k < 5; k++) begin
      clear_in(); disp(TW'(k + 50), 1'b0, 6'd21, 32'd0, 1'b1, 6'd0, 32'd0); cyc();
    end
    clear_in(); flush = 1'b1; disp(6'd60, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd2); cyc();
    clear_in(); settle();
    check("flush_occupancy", 32'(occupancy), 32'd0);
    check("flush_iss_valid", 32'(iss_valid), 32'd0);
    tick();

    // Random traffic with an asynchronous reset in the middle
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        rst_n = 1'b0;
        #1;
        check("async_rst_disp_ready", 32'(disp_ready), 32'd1);
        check("async_rst_iss_valid", 32'(iss_valid), 32'd0);
        check("async_rst_occupancy", 32'(occupancy), 32'd0);
        check("async_rst_iss_rd_tag", 32'(iss_rd_tag), 32'd0);
        check("async_rst_iss_rs1", iss_rs1_val, 32'd0);
        mq.delete(); eq.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
      clear_in();
      if ($urandom_range(0, 99) < 60)
        disp(TW'($urandom_range(0, 63)), ($urandom_range(0, 1) == 1), TW'($urandom_range(0, 7)),
             $urandom, ($urandom_range(0, 1) == 1), TW'($urandom_range(0, 7)), $urandom);
      cdb_valid = ($urandom_range(0, 99) < 40);
      cdb_tag   = TW'($urandom_range(0, 7));
      cdb_value = $urandom;
      iss_ready = ($urandom_range(0, 99) < 70);
      flush     = ($urandom_range(0, 49) == 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
